// File: rtl/lstm_dot_accum.sv
// ============================================================================
// Module      : lstm_dot_accum
// Description : Signed fixed-point multiply-accumulate over LEN operand pairs,
//               emitting one saturated, rescaled dot product per LEN beats.
//               Optional macro LSTM_DOT_ROUND_EN enables round-half-up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lstm_dot_accum #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LEN    = 8,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'((longint'(1) <<< (DATA_W - 1)) - longint'(1));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef LSTM_DOT_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = (FRAC_W > 0) ?
        ACC_W'(longint'(1) <<< ((FRAC_W > 0) ? (FRAC_W - 1) : 0)) : '0;
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]           count;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    rounded;
    logic signed [ACC_W-1:0]    shifted;
    logic                       sat_hi;
    logic                       sat_lo;
    logic [DATA_W-1:0]          res_data;
    logic                       res_ovf;
    logic                       accept;
    logic                       last_beat;
    logic                       transfer;

    // Operands widened to full product width so the multiply cannot truncate.
    assign prod = $signed({{DATA_W{in_a[DATA_W-1]}}, in_a}) *
                  $signed({{DATA_W{in_b[DATA_W-1]}}, in_b});

    assign acc_next  = acc + ACC_W'(prod);
    assign rounded   = acc_next + RND;
    assign shifted   = rounded >>> FRAC_W;
    assign sat_hi    = (shifted > SAT_MAX);
    assign sat_lo    = (shifted < SAT_MIN);
    assign res_ovf   = sat_hi || sat_lo;
    assign res_data  = sat_hi ? SAT_MAX[DATA_W-1:0] :
                       sat_lo ? SAT_MIN[DATA_W-1:0] : shifted[DATA_W-1:0];

    assign accept    = in_valid && (state == ACCUM);
    assign last_beat = accept && (count == LAST_CNT);
    assign transfer  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (transfer) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Accept and transfer are mutually exclusive: accept needs ACCUM, a
    // pending result only exists in HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                if (last_beat) begin
                    acc       <= '0;
                    count     <= '0;
                    out_valid <= 1'b1;
                    out_data  <= res_data;
                    out_ovf   <= res_ovf;
                end else begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                end
            end
            if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
